onehot_stream_encoder: RTL and testbench
========================================

// Module: onehot_stream_encoder
// PURPOSE
//   Inverse of the 3-to-8 one-hot decode in the base_conversion datapath. Accepts an
//   8-bit set vector and emits the 3-bit binary index of every set bit, one per
//   handshake, lowest index first. Also reports the vector's popcount and flags the
//   last index. Sits between the digit-select one-hot bus and the binary digit consumer.
// PARAMETERS
//   WIDTH    8                  input vector width; power of two, >= 2
//   IDX_W    $clog2(WIDTH) = 3  index width; derived, never overridden
//   CNT_W    $clog2(WIDTH+1)=4  popcount width; derived, never overridden
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_vec     in   WIDTH  vector to encode
//   in_valid   in   1      in_vec valid
//   in_ready   out  1      block can accept in_vec
//   out_idx    out  IDX_W  binary index of the current set bit
//   out_count  out  CNT_W  popcount of the accepted vector; held for the whole burst
//   out_last   out  1      current beat is the final beat of the burst
//   out_none   out  1      accepted vector was all-zero (single empty beat)
//   out_valid  out  1      out_* valid
//   out_ready  in   1      downstream accepts current beat
// BEHAVIOUR
//   - Reset (async assert, sync deassert by the system): state=IDLE, pending=0, out_idx=0,
//     out_count=0, out_last=0, out_none=0, out_valid=0. in_ready=1 in the first cycle
//     after deassert. Reset mid-burst discards all pending bits; no further beats.
//   - FSM: IDLE, EMIT. in_ready = (state==IDLE), combinational from state only.
//   - IDLE: on in_valid&&in_ready, register pending=in_vec, out_count=popcount(in_vec),
//     go to EMIT. out_valid=1 in the next cycle (latency 1 cycle).
//   - EMIT beat: out_idx = index of lowest set bit of pending; out_last=1 when pending
//     has exactly one set bit. out_* are registers, stable while out_valid&&!out_ready.
//   - On out_valid&&out_ready: clear that bit in pending. If out_last: out_valid=0
//     and state=IDLE next cycle (one bubble between bursts; no same-cycle reload).
//     Else next beat presented in the following cycle (1 beat/cycle under full ready).
//   - All-zero vector: one beat with out_none=1, out_last=1, out_idx=0, out_count=0.
//   - Full vector 8'hFF: 8 beats idx 0..7, out_count=8 (needs 4 bits), last on idx 7.
//   - in_vec/in_valid ignored while in EMIT; upstream must hold until in_ready.
//   - out_ready may be low indefinitely; no beat dropped or duplicated.
//   - Total cycles for k>0 set bits, ready held high: accept + k beats + 1 bubble.
// STRUCTURE
//   - base_conv_pkg: WIDTH default, IDX_W/CNT_W derivations, FSM state encoding
//     (ST_IDLE=1'b0, ST_EMIT=1'b1). Shared with the decoder side.
//   - Sub-module lowest_set_idx: combinational WIDTH->IDX_W lowest-set-bit finder
//     plus a "single bit remaining" flag; instantiated once on pending.
//   - Popcount is an inline adder tree in this module; the rest is a few registers.
// TESTING
//   1. in_vec=8'b0000_0100, out_ready=1 -> one beat idx=2, count=1, last=1, none=0;
//      out_valid exactly 1 cycle after accept; in_ready high again 1 cycle later.
//   2. in_vec=8'hA5, out_ready=1 -> idx 0,2,5,7 on consecutive cycles, count=4,
//      last only on idx 7.
//   3. in_vec=8'h00 -> single beat none=1, last=1, idx=0, count=0.
//   4. in_vec=8'hFF, out_ready toggled 1,0,0,1,... -> idx 0..7 in order, each held
//      stable while stalled, count=8, no drop/duplicate.
//   5. in_vec=8'hF0, rst_n pulled low after 2nd beat -> all outputs 0 asynchronously,
//      no beats after release, in_ready=1; next vector 8'h01 encodes idx=0 normally.
//   6. in_valid held high in EMIT with changing in_vec -> ignored; second vector
//      accepted only when in_ready=1 and encoded correctly.

Source files
------------

// File: rtl/base_conv_pkg.sv
// Shared definitions for the base_conversion one-hot encode/decode pair.
package base_conv_pkg;
  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/lowest_set_idx.sv
// Combinational lowest-set-bit finder with a "single bit remaining" flag.
module lowest_set_idx #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);
  // Scan high to low so the lowest set bit wins; all-zero yields 0.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
  end

  assign single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

// File: rtl/onehot_stream_encoder.sv
// Streams the binary index of every set bit of a vector, lowest first, with popcount.
module onehot_stream_encoder
  import base_conv_pkg::*;
#(
  parameter int WIDTH = base_conv_pkg::WIDTH,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             out_none,
  output logic             out_valid,
  input  logic             out_ready
);
  state_t           state, state_nxt;
  logic [WIDTH-1:0] pending, pending_nxt;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_single;
  logic [CNT_W-1:0] popcnt;
  logic             accept, fire;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) popcnt = popcnt + CNT_W'(in_vec[i]);
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    if (state == ST_IDLE) begin
      if (in_valid) begin
        pending_nxt = in_vec;
        state_nxt   = ST_EMIT;
      end
    end else if (fire) begin
      pending_nxt = pending & (pending - WIDTH'(1));
      if (out_last) state_nxt = ST_IDLE;
    end
  end

  // The finder looks at the next pending value so out_idx/out_last can be registers.
  lowest_set_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lsi (
    .vec    (pending_nxt),
    .idx    (nxt_idx),
    .single (nxt_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pending   <= '0;
      out_idx   <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      if (accept) begin
        out_count <= popcnt;
        out_none  <= (in_vec == '0);
        out_idx   <= nxt_idx;
        out_last  <= nxt_single || (in_vec == '0);
        out_valid <= 1'b1;
      end else if (fire) begin
        if (out_last) begin
          out_valid <= 1'b0;
        end else begin
          out_idx  <= nxt_idx;
          out_last <= nxt_single;
        end
      end
    end
  end
endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Directed + randomized bench for onehot_stream_encoder against a beat-list model.
module tb_onehot_stream_encoder;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_vec = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out_idx;
  logic [3:0] out_count;
  logic       out_last, out_none, out_valid;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int idx;
    int cnt;
    int last;
    int none;
  } beat_t;

  beat_t exp_q[$];

  onehot_stream_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: one beat per set bit in ascending order; empty vector gives one "none" beat.
  task automatic build_expect(input logic [7:0] v);
    int n, k;
    beat_t b;
    exp_q.delete();
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    if (n == 0) begin
      b = '{idx: 0, cnt: 0, last: 1, none: 1};
      exp_q.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < WIDTH; i++) begin
        if (v[i]) begin
          k++;
          b = '{idx: i, cnt: n, last: (k == n) ? 1 : 0, none: 0};
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Called at a negedge. mode: 0 ready high, 1 pattern 1,0,0, 2 random.
  // hold: keep in_valid high with junk during the burst (must be ignored).
  task automatic send(input logic [7:0] v, input int mode, input bit hold);
    int waitc, cyc;
    bit rdy;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_before_accept", int'(in_ready), 1);
    build_expect(v);
    in_vec   = v;
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    chk("latency_out_valid", int'(out_valid), 1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3) == 0;
        default: rdy = ($urandom % 4) != 0;
      endcase
      out_ready = rdy;
      if (hold) in_vec = 8'($urandom);
      chk("out_valid", int'(out_valid), 1);
      chk("in_ready_busy", int'(in_ready), 0);
      chk("out_idx", int'(out_idx), exp_q[0].idx);
      chk("out_count", int'(out_count), exp_q[0].cnt);
      chk("out_last", int'(out_last), exp_q[0].last);
      chk("out_none", int'(out_none), exp_q[0].none);
      if (rdy) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    chk("burst_done_in_budget", exp_q.size(), 0);
    out_ready = 1'b0;
    chk("bubble_out_valid", int'(out_valid), 0);
    chk("bubble_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_none", int'(out_none), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);

    send(8'b0000_0100, 0, 1'b0);
    send(8'hA5, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    send(8'hFF, 1, 1'b0);

    // Reset mid-burst on 8'hF0 after two beats have been taken
    build_expect(8'hF0);
    in_vec = 8'hF0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      chk("rst_burst_idx", int'(out_idx), exp_q[0].idx);
      chk("rst_burst_count", int'(out_count), 4);
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_out_idx", int'(out_idx), 0);
    chk("async_rst_out_count", int'(out_count), 0);
    chk("async_rst_out_last", int'(out_last), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_beats_after_rst", int'(out_valid), 0);
      chk("idle_after_rst", int'(in_ready), 1);
    end
    out_ready = 1'b0;
    send(8'h01, 0, 1'b0);

    // in_valid held through a burst with junk data; next vector chained right after
    send(8'h3C, 2, 1'b1);
    send(8'h81, 0, 1'b0);

    // Randomized vectors and backpressure
    for (int r = 0; r < 40; r++) begin
      send(8'($urandom), 2, ($urandom % 3) == 0);
    end
    in_valid = 1'b0;
    send(8'h80, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
